// File: rtl/dest_data_demux_pkg.sv
// Shared types for the destination data demux: sequence entry layout,
// FSM encoding and the clog2s helper.
package dest_data_demux_pkg;

    localparam int AXI_DATA_BITS = 512;
    localparam int BLEN_BITS     = 4;
    localparam int PID_BITS      = 6;
    localparam int DEST_BITS     = 4;

    typedef struct packed {
        logic [PID_BITS-1:0]  pid;
        logic [BLEN_BITS-1:0] len;
        logic [DEST_BITS-1:0] dest;
    } mux_user_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } seq_state_t;

    // clog2 that never returns 0, so a single destination still gets a 1-bit field
    function automatic int clog2s(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/dest_data_demux_if.sv
// Stream interfaces: meta_if carries sequence entries, axis_if an AXI4-Stream.
// Both use valid/ready: a transfer happens on a cycle where valid and ready are both high.
interface meta_if;
    import dest_data_demux_pkg::*;

    logic      valid;
    logic      ready;
    mux_user_t data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

interface axis_if #(
    parameter int DATA_BITS = 512
);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport m (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport s (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/dest_data_demux_seq.sv
// Sequencer for the data demux: pops sequence entries and counts beats so the
// top level knows which destination owns the current beat and when it is the last.
module dest_data_seq
    import dest_data_demux_pkg::*;
#(
    parameter int N_DESTS = 1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    meta_if.s                           s_mux,
    input  logic                        beat,
    output seq_state_t                  state,
    output logic [clog2s(N_DESTS)-1:0]  dest_r,
    output logic                        last,
    output logic                        vld_dest
);

    localparam int N_DESTS_BITS = clog2s(N_DESTS);

    seq_state_t           state_q, state_d;
    logic [BLEN_BITS-1:0] cnt_q;
    logic                 load;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (s_mux.valid) state_d = ST_BUSY;
            ST_BUSY: if (beat && last) state_d = s_mux.valid ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Entries are accepted only when idle or on the final beat, so back-to-back entries see no bubble
    always_comb begin
        s_mux.ready = 1'b0;
        if (aresetn) begin
            case (state_q)
                ST_IDLE: s_mux.ready = 1'b1;
                ST_BUSY: s_mux.ready = beat && last;
                default: s_mux.ready = 1'b0;
            endcase
        end
    end

    assign state = state_q;
    assign last  = (cnt_q == '0);
    assign load  = s_mux.valid && s_mux.ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q    <= '0;
            dest_r   <= '0;
            vld_dest <= 1'b1;
        end else if (load) begin
            cnt_q    <= s_mux.data.len;
            dest_r   <= s_mux.data.dest[N_DESTS_BITS-1:0];
            vld_dest <= (int'(s_mux.data.dest[N_DESTS_BITS-1:0]) < N_DESTS);
        end else if (beat && !last) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/dest_data_demux.sv
// Routes the shared returning data stream to per-destination streams following
// the popped sequence entries. Optional tlast framing check: DEST_DEMUX_TLAST_CHK_EN.
module dest_data_demux
    import dest_data_demux_pkg::*;
#(
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int N_DESTS   = 1
) (
    input  logic aclk,
    input  logic aresetn,
    meta_if.s    s_mux,
    axis_if.s    s_axis,
    axis_if.m    m_axis [N_DESTS],
    output logic err
);

    localparam int N_DESTS_BITS = clog2s(N_DESTS);
    localparam int N_SLOTS      = 1 << N_DESTS_BITS;

    seq_state_t              seq_state;
    logic                    busy;
    logic                    last;
    logic                    vld_dest;
    logic                    beat;
    logic [N_DESTS_BITS-1:0] dest_r;
    logic [N_SLOTS-1:0]      port_ready;

    dest_data_seq #(
        .N_DESTS (N_DESTS)
    ) u_seq (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_mux    (s_mux),
        .beat     (beat),
        .state    (seq_state),
        .dest_r   (dest_r),
        .last     (last),
        .vld_dest (vld_dest)
    );

    assign busy = (seq_state == ST_BUSY);

    // Pure pass-through: data is broadcast, only the selected port sees tvalid
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_port
        if (g < N_DESTS) begin : g_live
            assign m_axis[g].tvalid = busy && vld_dest && (dest_r == N_DESTS_BITS'(g)) && s_axis.tvalid;
            assign m_axis[g].tdata  = s_axis.tdata[DATA_BITS-1:0];
            assign m_axis[g].tkeep  = s_axis.tkeep[DATA_BITS/8-1:0];
            assign m_axis[g].tlast  = last;
            assign port_ready[g]    = m_axis[g].tready;
        end else begin : g_void
            assign port_ready[g] = 1'b0;
        end
    end

    // Beats for an unmapped destination are drained so the return path never locks up
    assign s_axis.tready = busy && (vld_dest ? port_ready[dest_r] : 1'b1);
    assign beat          = s_axis.tvalid && s_axis.tready;

`ifdef DEST_DEMUX_TLAST_CHK_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                           err <= 1'b0;
        else if (beat && (s_axis.tlast != last)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
